muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when not busy.
REQ-005 SHALL have port op  input  2  operation select: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 SHALL have port a  input  32  rs operand (multiplicand or dividend).
REQ-007 SHALL have port b  input  32  rt operand (multiplier or divisor).
REQ-008 SHALL have port hi_we  input  1  MTHI write strobe, writes a into HI.
REQ-009 SHALL have port lo_we  input  1  MTLO write strobe, writes a into LO.
REQ-010 SHALL have port hi  output  32  HI register (product high half or remainder).
REQ-011 SHALL have port lo  output  32  LO register (product low half or quotient).
REQ-012 SHALL have port busy  output  1  operation in progress; the datapath stalls MFHI/MFLO and further mult/div while it is high.
REQ-013 SHALL have port done  output  1  one-cycle pulse; HI/LO are valid in this cycle.
REQ-014 SHALL have port divzero  output  1  the completed divide had b==0; valid while done is high.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL accept start in IDLE or DONE: latch a, b and op, load the iteration counter with WIDTH, and enter RUN.
REQ-017 SHALL process one bit per cycle in RUN: shift-add for multiply, restoring shift-subtract for divide; the counter decrements by 1 each edge.
REQ-018 SHALL write HI/LO and enter DONE on the RUN edge where the counter reaches 0, giving a latency of exactly WIDTH edges from the accepting edge to the result.
REQ-019 SHALL drive busy=1 only in RUN and done=1 only in DONE; DONE returns to IDLE after one cycle unless start is accepted.
REQ-020 SHALL ignore start, hi_we and lo_we while busy; operands are not re-sampled during RUN.
REQ-021 SHALL give start priority when start and hi_we/lo_we arrive together when not busy; the write is dropped.
REQ-022 SHALL form the multiply as a full 2*WIDTH-bit product: HI = bits [63:32], LO = bits [31:0]; there is no overflow.
REQ-023 SHALL produce LO = quotient and HI = remainder for a divide.
REQ-024 SHALL produce LO = 32'hFFFFFFFF, HI = a and divzero=1 when the divisor is 0; HI/LO are still written.
REQ-025 SHALL keep divzero low for multiplies and for non-zero divisors.

Reset
REQ-026 SHALL, while reset is high, force state IDLE, HI=LO=0, busy=0, done=0, divzero=0 and counter=0.
REQ-027 SHALL abandon any operation in progress when reset is asserted in RUN; no partial result reaches HI/LO.

Configuration
REQ-028 SHALL support macro MULDIV_SIGNED_EN.
REQ-029 SHALL, with MULDIV_SIGNED_EN defined, run MULT/DIV on operand magnitudes and fix signs on completion, with no extra cycle.
REQ-030 SHALL, in that signed mode, negate the product when sign(a)^sign(b); the quotient takes sign(a)^sign(b) and the remainder takes sign(a).
REQ-031 SHALL, in that signed mode, give a signed divide by 0 the same result as REQ-024.
REQ-032 SHALL, without MULDIV_SIGNED_EN, ignore op[1] so that MULT/DIV behave as MULTU/DIVU.

Structure
REQ-033 SHALL place the op encodings, the FSM state enum and the WIDTH constant in shared package muldiv_pkg.
REQ-034 SHALL put the single-iteration combinational step (add/subtract and shift of the accumulator) in sub-module muldiv_step; the FSM, counter and sign fix-up stay in muldiv_unit.

Verification
REQ-035 SHALL verify MULTU a=7, b=6 -> busy for 32 cycles, then done=1 with HI=0, LO=42.
REQ-036 SHALL verify MULTU a=b=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-037 SHALL verify DIVU 100/7 -> LO=14, HI=2, divzero=0; then DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5, divzero=1.
REQ-038 SHALL verify, with MULDIV_SIGNED_EN, MULT -3*5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1, and DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-039 SHALL verify start pulsed with new operands and hi_we=1 at RUN cycle 10 -> both ignored, result matches the original operands, done at edge 32.
REQ-040 SHALL verify reset asserted at RUN cycle 15 -> next cycle IDLE, HI=LO=0, busy=0; a following start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operand width, op encodings, FSM states.
package muldiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring shift-subtract for divide, operating on the {acc_hi, acc_lo} pair.
module muldiv_step #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the running partial product.
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle, WIDTH-cycle latency.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise op[1] is ignored.
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, operand_reg, a_orig_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               is_div_reg, neg_q_reg, neg_r_reg, zero_div_reg, divzero_reg;

  logic               signed_op, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = op[1];
`else
  logic op_hi_unused;
  assign op_hi_unused = op[1];
  assign signed_op    = 1'b0;
`endif

  assign a_neg  = signed_op & a[WIDTH-1];
  assign b_neg  = signed_op & b[WIDTH-1];
  assign a_mag  = cond_neg(a, a_neg);
  assign b_mag  = cond_neg(b, b_neg);
  assign accept = start && (state_reg != ST_RUN);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_reg),
    .acc_hi  (acc_hi_reg),
    .acc_lo  (acc_lo_reg),
    .operand (operand_reg),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Sign fix-up is applied to the final step's output so no extra cycle is spent.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (zero_div_reg) begin
        res_hi = a_orig_reg;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = cond_neg(step_hi, neg_r_reg);
        res_lo = cond_neg(step_lo, neg_q_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      operand_reg  <= '0;
      a_orig_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      divzero_reg  <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      acc_hi_reg <= step_hi;
      acc_lo_reg <= step_lo;
      cnt_reg    <= cnt_reg - 1'b1;
      if (cnt_reg == CNT_W'(1)) begin
        hi_reg      <= res_hi;
        lo_reg      <= res_lo;
        divzero_reg <= zero_div_reg;
        state_reg   <= ST_DONE;
      end
    end else begin
      divzero_reg <= 1'b0;
      if (accept) begin
        // Start wins over a coincident MTHI/MTLO; the write is dropped.
        state_reg    <= ST_RUN;
        cnt_reg      <= CNT_W'(WIDTH);
        is_div_reg   <= op[0];
        acc_hi_reg   <= '0;
        acc_lo_reg   <= op[0] ? a_mag : b_mag;
        operand_reg  <= op[0] ? b_mag : a_mag;
        a_orig_reg   <= a;
        neg_q_reg    <= a_neg ^ b_neg;
        neg_r_reg    <= a_neg;
        zero_div_reg <= op[0] && (b == '0);
      end else begin
        state_reg <= ST_IDLE;
        if (hi_we) hi_reg <= a;
        if (lo_we) lo_reg <= a;
      end
    end
  end

  assign hi      = hi_reg;
  assign lo      = lo_reg;
  assign busy    = (state_reg == ST_RUN);
  assign done    = (state_reg == ST_DONE);
  assign divzero = divzero_reg;

endmodule
